rv_fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the RV32I pipeline, replacing the bare PC-plus-4 fetch path ahead of decode. It owns the fetch PC, issues word requests over a valid/ready instruction-memory port, buffers returned instructions in a FIFO, and hands them to decode over a valid/ready interface. Branch/jump redirects from execute flush the buffer and discard any in-flight response. Memory errors and misaligned targets are reported as faulting entries.

---
 rtl/rv_fetch_unit.sv | 185 ++++++++++++++++++
 tb/tb_rv_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_fetch_unit.sv
// RV32I instruction-fetch front end: one outstanding word request at a time,
// returned words buffered in a small FIFO toward decode, redirect flush and fault entries.
module rv_fetch_unit #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [31:0]                 imem_rsp_data,
    input  logic                        imem_rsp_err,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        if_valid,
    input  logic                        if_ready,
    output logic [31:0]                 if_instr,
    output logic [XLEN-1:0]             if_pc,
    output logic                        if_fault,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_HALT  = 2'd3;

    localparam logic [31:0]     NOP_INSTR  = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(32'd4);
    localparam logic [CW-1:0]   FULL_COUNT = CW'(FIFO_DEPTH);

    logic [1:0]            state_r, state_s;
    logic [XLEN-1:0]       fetch_pc_r, fetch_pc_s;
    logic [XLEN-1:0]       req_pc_r, req_pc_s;
    logic                  halt_pend_r, halt_pend_s;
    logic [31:0]           instr_mem_r [FIFO_DEPTH];
    logic [XLEN-1:0]       pc_mem_r    [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] fault_mem_r;
    logic [AW-1:0]         rd_ptr_r, wr_ptr_r, wr_idx_s;
    logic [CW-1:0]         count_r;
    logic                  req_fire_s, outstanding_s, flush_s, push_s, pop_s;
    logic [31:0]           push_instr_s;
    logic [XLEN-1:0]       push_pc_s;
    logic                  push_fault_s;

    // Output decode from registered state; the request is held off while reset is asserted.
    always_comb begin
        if_valid = (count_r != {CW{1'b0}});
        if (if_valid) begin
            if_instr = instr_mem_r[rd_ptr_r];
            if_pc    = pc_mem_r[rd_ptr_r];
            if_fault = fault_mem_r[rd_ptr_r];
        end else begin
            if_instr = 32'h0000_0000;
            if_pc    = {XLEN{1'b0}};
            if_fault = 1'b0;
        end
        imem_req_valid = reset && (state_r == ST_IDLE) && (count_r < FULL_COUNT);
        imem_req_addr  = fetch_pc_r;
        fifo_count     = count_r;
    end

    // Next-state, FIFO push/pop/flush decisions; a redirect overrides everything else.
    always_comb begin
        state_s      = state_r;
        fetch_pc_s   = fetch_pc_r;
        req_pc_s     = req_pc_r;
        halt_pend_s  = halt_pend_r;
        push_s       = 1'b0;
        push_instr_s = imem_rsp_data;
        push_pc_s    = req_pc_r;
        push_fault_s = imem_rsp_err;
        flush_s      = 1'b0;
        pop_s        = 1'b0;
        req_fire_s   = imem_req_valid && imem_req_ready;
        // A response landing in the redirect cycle retires the request, so nothing is left to drain.
        outstanding_s = (((state_r == ST_WAIT) || (state_r == ST_DRAIN)) && !imem_rsp_valid)
                        || req_fire_s;
        if (redirect_valid) begin
            flush_s    = 1'b1;
            fetch_pc_s = redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
                push_s       = 1'b1;
                push_instr_s = NOP_INSTR;
                push_pc_s    = redirect_pc;
                push_fault_s = 1'b1;
                if (outstanding_s) begin
                    state_s     = ST_DRAIN;
                    halt_pend_s = 1'b1;
                end else begin
                    state_s     = ST_HALT;
                    halt_pend_s = 1'b0;
                end
            end else begin
                halt_pend_s = 1'b0;
                if (outstanding_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
        end else begin
            pop_s = if_valid && if_ready;
            case (state_r)
                ST_IDLE: begin
                    if (req_fire_s) begin
                        state_s    = ST_WAIT;
                        req_pc_s   = fetch_pc_r;
                        fetch_pc_s = fetch_pc_r + PC_STEP;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        push_s  = 1'b1;
                        state_s = imem_rsp_err ? ST_HALT : ST_IDLE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_s     = halt_pend_r ? ST_HALT : ST_IDLE;
                        halt_pend_s = 1'b0;
                    end else begin
                        state_s = ST_DRAIN;
                    end
                end
                ST_HALT: begin
                    state_s = ST_HALT;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
        wr_idx_s = flush_s ? {AW{1'b0}} : wr_ptr_r;
    end

    // Control state, pointers and occupancy with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            fetch_pc_r  <= RESET_PC;
            req_pc_r    <= {XLEN{1'b0}};
            halt_pend_r <= 1'b0;
            rd_ptr_r    <= {AW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
        end else begin
            state_r     <= state_s;
            fetch_pc_r  <= fetch_pc_s;
            req_pc_r    <= req_pc_s;
            halt_pend_r <= halt_pend_s;
            if (flush_s) begin
                rd_ptr_r <= {AW{1'b0}};
                wr_ptr_r <= push_s ? AW'(1'b1) : {AW{1'b0}};
                count_r  <= CW'(push_s);
            end else begin
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1'b1);
                end
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + AW'(1'b1);
                end
                count_r <= count_r + CW'(push_s) - CW'(pop_s);
            end
        end
    end

    // Entry storage; contents are masked by occupancy so no reset is needed here.
    always_ff @(posedge clk) begin
        if (reset && push_s) begin
            instr_mem_r[wr_idx_s] <= push_instr_s;
            pc_mem_r[wr_idx_s]    <= push_pc_s;
            fault_mem_r[wr_idx_s] <= push_fault_s;
        end
    end
endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit: queue-based reference model checked every cycle,
// plus literal checkpoints and a wrap-around instance with RESET_PC=0xFFFFFFFC.
module tb_rv_fetch_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready, if_fault;
    logic [31:0] if_instr, if_pc;
    logic [2:0]  fifo_count;

    logic        w_reset, w_req_valid, w_req_ready, w_rsp_valid, w_rsp_err;
    logic [31:0] w_req_addr, w_rsp_data, w_redirect_pc, w_if_instr, w_if_pc;
    logic        w_redirect_valid, w_if_valid, w_if_ready, w_if_fault;
    logic [2:0]  w_fifo_count;

    int n_cmp = 0;
    int n_err = 0;
    int n_req;

    // reference model
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_busy_pc;
    logic        m_busy, m_stale, m_halt;
    // memory model
    int          lat;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic [31:0] err_addr;

    rv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
        .if_pc(if_pc), .if_fault(if_fault), .fifo_count(fifo_count)
    );

    rv_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk(clk), .reset(w_reset),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
        .imem_req_addr(w_req_addr), .imem_rsp_valid(w_rsp_valid),
        .imem_rsp_data(w_rsp_data), .imem_rsp_err(w_rsp_err),
        .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc),
        .if_valid(w_if_valid), .if_ready(w_if_ready), .if_instr(w_if_instr),
        .if_pc(w_if_pc), .if_fault(w_if_fault), .fifo_count(w_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_reqv();
        return reset && !m_busy && !m_halt && (m_q.size() < DEPTH);
    endfunction

    // Advance the model by one clock edge from the inputs presented during the cycle.
    task automatic model_edge(output logic fire, output logic [31:0] faddr);
        logic rsp, still_busy, reqv;
        reqv  = m_reqv();
        fire  = 1'b0;
        faddr = m_pc;
        if (!reset) begin
            m_q.delete();
            m_pc = 32'h0000_0000; m_busy = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
        end else begin
            fire = reqv && imem_req_ready;
            rsp  = imem_rsp_valid && m_busy;
            if (redirect_valid) begin
                m_q.delete();
                still_busy = (m_busy && !rsp) || fire;
                m_busy  = still_busy;
                m_stale = still_busy;
                m_pc    = redirect_pc;
                if (redirect_pc[1:0] != 2'b00) begin
                    m_q.push_back('{instr: 32'h0000_0013, pc: redirect_pc, fault: 1'b1});
                    m_halt = 1'b1;
                end else begin
                    m_halt = 1'b0;
                end
            end else begin
                if (m_q.size() > 0 && if_ready) void'(m_q.pop_front());
                if (fire) begin
                    m_busy = 1'b1; m_busy_pc = m_pc; m_pc = m_pc + 32'd4;
                end else if (rsp) begin
                    m_busy = 1'b0;
                    if (m_stale) begin
                        m_stale = 1'b0;
                    end else begin
                        m_q.push_back('{instr: imem_rsp_data, pc: m_busy_pc, fault: imem_rsp_err});
                        if (imem_rsp_err) m_halt = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic compare();
        ent_t h;
        h = (m_q.size() > 0) ? m_q[0] : '0;
        chk("req_valid", {31'b0, imem_req_valid}, {31'b0, m_reqv()});
        if (m_reqv()) chk("req_addr", imem_req_addr, m_pc);
        chk("if_valid", {31'b0, if_valid}, {31'b0, (m_q.size() > 0)});
        chk("fifo_count", {29'b0, fifo_count}, 32'(m_q.size()));
        chk("if_instr", if_instr, h.instr);
        chk("if_pc", if_pc, h.pc);
        chk("if_fault", {31'b0, if_fault}, {31'b0, h.fault});
    endtask

    // One clock: model and memory react to the edge, then outputs are checked 1ns later.
    task automatic step();
        logic fire;
        logic [31:0] faddr;
        @(posedge clk);
        model_edge(fire, faddr);
        if (mem_wait > 0) mem_wait--;
        if (fire) begin
            mem_wait = lat;
            mem_addr = faddr;
        end
        #1;
        imem_rsp_valid = (mem_wait == 1);
        imem_rsp_data  = imem_rsp_valid ? (mem_addr ^ 32'hFFFF_FFFF) : 32'h0000_0000;
        imem_rsp_err   = imem_rsp_valid && (mem_addr == err_addr);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0; imem_rsp_err = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; if_ready = 1'b0;
        w_reset = 1'b0; w_req_ready = 1'b0; w_rsp_valid = 1'b0; w_rsp_data = 32'h0;
        w_rsp_err = 1'b0; w_redirect_valid = 1'b0; w_redirect_pc = 32'h0; w_if_ready = 1'b0;
        m_pc = 32'h0; m_busy_pc = 32'h0; m_busy = 1'b0; m_stale = 1'b0; m_halt = 1'b0;
        lat = 1; mem_wait = 0; mem_addr = 32'h0; err_addr = 32'hFFFF_FFF1;

        // reset state and streaming with zero-wait memory
        do_reset();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_count", {29'b0, fifo_count}, 32'd0);
        if_ready = 1'b1;
        #1;
        chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("first_req_addr", imem_req_addr, 32'h0000_0000);
        for (int k = 0; k < 4; k++) begin
            step();
            step();
            chk("stream_pc", if_pc, 32'(k * 4));
            chk("stream_instr", if_instr, ~(32'(k * 4)));
        end

        // backpressure fills the buffer, then fetching resumes at 0x10
        do_reset();
        if_ready = 1'b0;
        n_req = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            if (imem_req_valid === 1'b1) n_req++;
            step();
        end
        chk("full_req_count", 32'(n_req), 32'd4);
        chk("full_count", {29'b0, fifo_count}, 32'd4);
        chk("full_req_valid", {31'b0, imem_req_valid}, 32'd0);
        if_ready = 1'b1;
        step();
        chk("resume_count", {29'b0, fifo_count}, 32'd3);
        chk("resume_addr", imem_req_addr, 32'h0000_0010);
        for (int k = 0; k < 8; k++) step();

        // redirect while a slow response is outstanding
        do_reset();
        lat = 3; if_ready = 1'b0;
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
        step();
        redirect_valid = 1'b0;
        chk("redir_if_valid", {31'b0, if_valid}, 32'd0);
        chk("redir_drain_req", {31'b0, imem_req_valid}, 32'd0);
        for (int k = 0; k < 20 && imem_req_valid !== 1'b1; k++) step();
        chk("redir_req_addr", imem_req_addr, 32'h0000_0100);
        for (int k = 0; k < 20 && if_valid !== 1'b1; k++) step();
        chk("redir_if_pc", if_pc, 32'h0000_0100);
        chk("redir_if_instr", if_instr, 32'hFFFF_FEFF);

        // access fault at 0x8 halts fetch until a redirect
        do_reset();
        lat = 1; if_ready = 1'b1; err_addr = 32'h0000_0008;
        for (int k = 0; k < 30 && !(if_valid === 1'b1 && if_fault === 1'b1); k++) step();
        chk("err_pc", if_pc, 32'h0000_0008);
        chk("err_instr", if_instr, 32'hFFFF_FFF7);
        chk("err_fault", {31'b0, if_fault}, 32'd1);
        n_req = 0;
        for (int k = 0; k < 6; k++) begin
            if (imem_req_valid === 1'b1) n_req++;
            step();
        end
        chk("halt_no_req", 32'(n_req), 32'd0);
        err_addr = 32'hFFFF_FFF1;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect_valid = 1'b0;
        chk("halt_exit_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("halt_exit_addr", imem_req_addr, 32'h0000_0040);

        // misaligned redirect while the 0x40 request is accepted in the same cycle
        if_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        step();
        redirect_valid = 1'b0;
        chk("mis_count", {29'b0, fifo_count}, 32'd1);
        chk("mis_pc", if_pc, 32'h0000_0102);
        chk("mis_instr", if_instr, 32'h0000_0013);
        chk("mis_fault", {31'b0, if_fault}, 32'd1);
        n_req = 0;
        for (int k = 0; k < 8; k++) begin
            if (imem_req_valid === 1'b1) n_req++;
            step();
        end
        chk("mis_no_req", 32'(n_req), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        step();
        redirect_valid = 1'b0;
        chk("mis_exit_addr", imem_req_addr, 32'h0000_0200);
        chk("mis_exit_valid", {31'b0, imem_req_valid}, 32'd1);

        // reset asserted while a request is outstanding
        do_reset();
        lat = 3; if_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
        chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("midrst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("midrst_count", {29'b0, fifo_count}, 32'd0);
        chk("midrst_if_pc", if_pc, 32'd0);
        chk("midrst_if_instr", if_instr, 32'd0);
        chk("midrst_if_fault", {31'b0, if_fault}, 32'd0);
        step();
        step();
        reset = 1'b1;
        #1;
        chk("postrst_addr", imem_req_addr, 32'h0000_0000);
        for (int k = 0; k < 10; k++) step();

        // wrap-around from RESET_PC = 0xFFFFFFFC
        chk("wrap_rst_req", {31'b0, w_req_valid}, 32'd0);
        w_reset = 1'b1; w_req_ready = 1'b1;
        #1;
        chk("wrap_req0_valid", {31'b0, w_req_valid}, 32'd1);
        chk("wrap_req0_addr", w_req_addr, 32'hFFFF_FFFC);
        step();
        w_rsp_valid = 1'b1; w_rsp_data = 32'h0000_0003;
        chk("wrap_wait_req", {31'b0, w_req_valid}, 32'd0);
        step();
        w_rsp_valid = 1'b0;
        chk("wrap_if_valid", {31'b0, w_if_valid}, 32'd1);
        chk("wrap_if_pc", w_if_pc, 32'hFFFF_FFFC);
        chk("wrap_if_instr", w_if_instr, 32'h0000_0003);
        chk("wrap_req1_valid", {31'b0, w_req_valid}, 32'd1);
        chk("wrap_req1_addr", w_req_addr, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
